calc_queue_ctrl: RTL and testbench

Parametrised circular-buffer operand queue for the queue-based calculator datapath, replacing the fixed 5x8 shift-register queue.
- Holds DEPTH operands of DATA_W bits.
- Always presents the front pair to the ALU for pre-computation.
- Executes PUSH, REDUCE (drop front pair, append ALU result), POP and CLEAR.
- Provides count/full/empty status and a sticky error flag with explicit clear.

---
 rtl/calc_queue_ctrl.sv | 134 +++++++++++++
 tb/tb_calc_queue_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/calc_queue_ctrl.sv
// Circular-buffer operand queue for the queue-based calculator: PUSH, CLEAR, REDUCE, POP.
// Optional build macro QCTRL_ERR_CODE_EN adds an err_code output that records the first rejected op.
`timescale 1ns/1ps
module calc_queue_ctrl #(
  parameter int                DATA_W  = 8,
  parameter int                DEPTH   = 5,
  parameter logic [DATA_W-1:0] PAD_VAL = {DATA_W{1'b1}},
  parameter int                CNT_W   = $clog2(DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  op_valid,
  input  logic [1:0]            opcode,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  err_clr,
  output logic [2*DATA_W-1:0]   top_pair,
  output logic [DATA_W-1:0]     tail,
  output logic [CNT_W-1:0]      count,
  output logic                  empty,
  output logic                  full,
  output logic                  err
`ifdef QCTRL_ERR_CODE_EN
  ,
  output logic [1:0]            err_code
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH-1);

  localparam logic [1:0] OP_PUSH   = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_REDUCE = 2'b10;
  localparam logic [1:0] OP_POP    = 2'b11;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_wr;
  logic [CNT_W-1:0]  r_count;
  logic              r_err;

  logic w_push, w_clear, w_reduce, w_pop;
  logic w_full, w_empty, w_ge2;
  logic w_push_ok, w_pop_ok, w_red_ok, w_reject;
  logic [PTR_W-1:0] w_head_p1, w_head_p2, w_wr_m1;

  // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] f_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? LAST : p - PTR_W'(1);
  endfunction

  always_comb begin
    w_push    = op_valid && (opcode == OP_PUSH);
    w_clear   = op_valid && (opcode == OP_CLEAR);
    w_reduce  = op_valid && (opcode == OP_REDUCE);
    w_pop     = op_valid && (opcode == OP_POP);
    w_full    = (r_count == CNT_W'(DEPTH));
    w_empty   = (r_count == '0);
    w_ge2     = (r_count >= CNT_W'(2));
    w_push_ok = w_push && !w_full;
    w_pop_ok  = w_pop && !w_empty;
    w_red_ok  = w_reduce && w_ge2;
    w_reject  = (w_push && w_full) || (w_pop && w_empty) || (w_reduce && !w_ge2);
    w_head_p1 = f_inc(r_head);
    w_head_p2 = f_inc(w_head_p1);
    w_wr_m1   = f_dec(r_wr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_head  <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      // REDUCE frees the front pair and appends the ALU result in the same edge.
      if (w_push_ok || w_red_ok) begin
        r_mem[r_wr] <= data_in;
        r_wr        <= f_inc(r_wr);
      end
      if (w_clear) begin
        r_head  <= r_wr;
        r_count <= '0;
      end else if (w_push_ok) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop_ok) begin
        r_head  <= w_head_p1;
        r_count <= r_count - CNT_W'(1);
      end else if (w_red_ok) begin
        r_head  <= w_head_p2;
        r_count <= r_count - CNT_W'(1);
      end
      if (w_reject)     r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;
    end
  end

`ifdef QCTRL_ERR_CODE_EN
  logic [1:0] r_err_code;
  logic [1:0] w_new_code;

  always_comb begin
    w_new_code = 2'b00;
    if (w_push && w_full)        w_new_code = 2'b01;
    else if (w_pop && w_empty)   w_new_code = 2'b10;
    else if (w_reduce && !w_ge2) w_new_code = 2'b11;
  end

  // First error wins while err is held; a clear in the same cycle admits the new code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              r_err_code <= 2'b00;
    else if (w_reject && (!r_err || err_clr)) r_err_code <= w_new_code;
    else if (err_clr && !w_reject)        r_err_code <= 2'b00;
  end

  assign err_code = r_err_code;
`endif

  always_comb begin
    top_pair[DATA_W-1:0]        = (r_count >= CNT_W'(1)) ? r_mem[r_head] : PAD_VAL;
    top_pair[2*DATA_W-1:DATA_W] = w_ge2 ? r_mem[w_head_p1] : PAD_VAL;
    tail                        = (r_count >= CNT_W'(1)) ? r_mem[w_wr_m1] : PAD_VAL;
    count                       = r_count;
    empty                       = w_empty;
    full                        = w_full;
    err                         = r_err;
  end

endmodule

// File: tb/tb_calc_queue_ctrl.sv
// Bench for calc_queue_ctrl: directed test-plan steps followed by random ops,
// each checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_calc_queue_ctrl;

  localparam int DEPTH = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [1:0]  opcode;
  logic [7:0]  data_in;
  logic        err_clr;
  logic [15:0] top_pair;
  logic [7:0]  tail;
  logic [2:0]  count;
  logic        empty;
  logic        full;
  logic        err;
`ifdef QCTRL_ERR_CODE_EN
  logic [1:0]  err_code;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] m_q[$];
  logic       m_err;
  logic [1:0] m_code;

  calc_queue_ctrl dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .opcode(opcode),
    .data_in(data_in), .err_clr(err_clr), .top_pair(top_pair), .tail(tail),
    .count(count), .empty(empty), .full(full), .err(err)
`ifdef QCTRL_ERR_CODE_EN
    , .err_code(err_code)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_err  = 1'b0;
    m_code = 2'b00;
  endtask

  // Behavioural queue semantics: rejected ops leave the list untouched.
  task automatic model_step(input logic v, input logic [1:0] opc, input logic [7:0] d, input logic clr);
    logic [1:0] bad;
    bad = 2'b00;
    if (v) begin
      case (opc)
        2'b00: if (m_q.size() == DEPTH) bad = 2'b01; else m_q.push_back(d);
        2'b01: m_q.delete();
        2'b10: if (m_q.size() < 2) bad = 2'b11;
               else begin void'(m_q.pop_front()); void'(m_q.pop_front()); m_q.push_back(d); end
        default: if (m_q.size() == 0) bad = 2'b10; else void'(m_q.pop_front());
      endcase
    end
    if (bad != 2'b00) begin
      if (!m_err || clr) m_code = bad;
      m_err = 1'b1;
    end else if (clr) begin
      m_err  = 1'b0;
      m_code = 2'b00;
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] f, s, t;
    f = (m_q.size() >= 1) ? m_q[0] : 8'hFF;
    s = (m_q.size() >= 2) ? m_q[1] : 8'hFF;
    t = (m_q.size() >= 1) ? m_q[m_q.size()-1] : 8'hFF;
    chk({tag, ".count"}, 32'(count), 32'(m_q.size()));
    chk({tag, ".empty"}, 32'(empty), 32'(m_q.size() == 0));
    chk({tag, ".full"},  32'(full),  32'(m_q.size() == DEPTH));
    chk({tag, ".err"},   32'(err),   32'(m_err));
    chk({tag, ".top"},   32'(top_pair), {16'h0, s, f});
    chk({tag, ".tail"},  32'(tail),  32'(t));
`ifdef QCTRL_ERR_CODE_EN
    chk({tag, ".code"},  32'(err_code), 32'(m_code));
`endif
  endtask

  task automatic do_op(input string tag, input logic v, input logic [1:0] opc,
                       input logic [7:0] d, input logic clr);
    op_valid = v; opcode = opc; data_in = d; err_clr = clr;
    @(posedge clk);
    #1;
    model_step(v, opc, d, clr);
    op_valid = 1'b0; err_clr = 1'b0;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; opcode = 2'b00; data_in = 8'h00; err_clr = 1'b0;
    model_reset();
    #12 rst = 1'b0;
    check_all("reset");

    do_op("push11", 1, 2'b00, 8'h11, 0);
    do_op("push22", 1, 2'b00, 8'h22, 0);
    do_op("push33", 1, 2'b00, 8'h33, 0);
    chk("tp1.top", 32'(top_pair), 32'h2211);
    do_op("red44", 1, 2'b10, 8'h44, 0);
    chk("tp2.top", 32'(top_pair), 32'h4433);
    do_op("red55", 1, 2'b10, 8'h55, 0);
    chk("tp3.top", 32'(top_pair), 32'hFF55);
    do_op("idle", 0, 2'b00, 8'hAA, 0);

    do_op("clr0", 1, 2'b01, 8'h00, 0);
    for (int i = 1; i <= 5; i++) do_op("fill", 1, 2'b00, 8'(i), 0);
    do_op("ovf", 1, 2'b00, 8'h06, 0);
    chk("ovf.err", 32'(err), 32'h1);
    do_op("redfull", 1, 2'b10, 8'h0A, 0);
    chk("wrap.top", 32'(top_pair), 32'h0403);
    do_op("errclr", 0, 2'b00, 8'h00, 1);

    do_op("clr1", 1, 2'b01, 8'h00, 0);
    do_op("popemp", 1, 2'b11, 8'h00, 0);
    do_op("errclr2", 0, 2'b00, 8'h00, 1);
    do_op("push1", 1, 2'b00, 8'h99, 0);
    do_op("red1clr", 1, 2'b10, 8'h77, 1);
    chk("setwins.err", 32'(err), 32'h1);
    do_op("pop1", 1, 2'b11, 8'h00, 0);

    do_op("p3a", 1, 2'b00, 8'hA1, 0);
    do_op("p3b", 1, 2'b00, 8'hA2, 0);
    do_op("p3c", 1, 2'b00, 8'hA3, 0);
    do_op("clr3", 1, 2'b01, 8'h00, 0);
    chk("clr3.top", 32'(top_pair), 32'hFFFF);
    do_op("push7e", 1, 2'b00, 8'h7E, 0);
    chk("push7e.top", 32'(top_pair), 32'hFF7E);

    // Build 4 entries with err set, then hit reset between clock edges.
    for (int i = 0; i < 3; i++) do_op("p4", 1, 2'b00, 8'(8'hC0 + i), 0);
    do_op("red_bad_none", 1, 2'b11, 8'h00, 0);
    do_op("p4b", 1, 2'b00, 8'hC5, 0);
    do_op("p4c", 1, 2'b00, 8'hC6, 0);
    do_op("pop_ovf", 1, 2'b00, 8'hC7, 0);
    do_op("push_ovf", 1, 2'b00, 8'hC8, 0);
    do_op("pop", 1, 2'b11, 8'h00, 0);
    chk("pre_rst.err", 32'(err), 32'h1);
    op_valid = 1'b1; opcode = 2'b00; data_in = 8'hEE;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    op_valid = 1'b0;
    #3 rst = 1'b0;
    @(negedge clk);
    check_all("post_rst");

    for (int n = 0; n < 400; n++) begin
      logic [1:0] opc;
      int r;
      r = $urandom_range(0, 9);
      opc = (r < 4) ? 2'b00 : (r < 6) ? 2'b10 : (r < 9) ? 2'b11 : 2'b01;
      do_op("rand", ($urandom_range(0, 7) != 0), opc, 8'($urandom_range(0, 255)),
            ($urandom_range(0, 7) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
